bist_scheduler: RTL and testbench

Session controller that runs up to NUM_UNITS BIST state-machine units one after another from a single start request. For each unit it issues a one-cycle start pulse, waits for that unit's end flag to rise, and records pass/fail or timeout. It then reports an aggregated result. It sits between the test-access/config logic and the per-memory BIST units, driving each unit's bist_start and observing its bist_end.

---
 rtl/bist_sched_pkg.sv | 23 ++
 rtl/bist_sched_timer.sv | 35 +++
 rtl/bist_scheduler.sv | 173 +++++++++++++++++
 tb/tb_bist_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_sched_pkg.sv
// rtl/bist_sched_pkg.sv - state encodings and default sizing for the BIST session scheduler
package bist_sched_pkg;

    localparam int DEF_NUM_UNITS = 4;
    localparam int DEF_TIMEOUT   = 255;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SCAN   = 3'd1;
    localparam logic [2:0] ST_LAUNCH = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_NEXT   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_SCAN   = ST_SCAN,
        S_LAUNCH = ST_LAUNCH,
        S_WAIT   = ST_WAIT,
        S_NEXT   = ST_NEXT,
        S_DONE   = ST_DONE
    } state_e;

endpackage

// File: rtl/bist_sched_timer.sv
// rtl/bist_sched_timer.sv - per-unit WAIT timer with clear, enable and expiry flag
module bist_sched_timer #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = $clog2(TIMEOUT)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    logic [TO_W-1:0] count_q;
    logic [TO_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/bist_scheduler.sv
// rtl/bist_scheduler.sv - runs masked BIST units one at a time and aggregates pass/fail/timeout
module bist_scheduler
    import bist_sched_pkg::*;
#(
    parameter int NUM_UNITS = DEF_NUM_UNITS,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int UNIT_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
    parameter int TO_W      = $clog2(TIMEOUT)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [NUM_UNITS-1:0] unit_mask_i,
    input  logic [NUM_UNITS-1:0] unit_end_i,
    input  logic [NUM_UNITS-1:0] unit_fail_i,
    output logic [NUM_UNITS-1:0] unit_start_o,
    output logic [UNIT_W-1:0]    cur_unit_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic                 aborted_o,
    output logic [NUM_UNITS-1:0] fail_map_o,
    output logic [NUM_UNITS-1:0] timeout_map_o
);

    state_e               state_q, state_d;
    logic [UNIT_W-1:0]    idx_q, idx_d;
    logic [NUM_UNITS-1:0] mask_q, mask_d;
    logic [NUM_UNITS-1:0] fail_q, fail_d;
    logic [NUM_UNITS-1:0] tmo_q, tmo_d;
    logic                 aborted_q, aborted_d;
    logic                 result_q, result_d;
    logic                 end_prev_q, end_prev_d;
    logic                 start_prev_q;

    logic accept;
    logic active;
    logic last_unit;
    logic rise;
    logic expired;

    assign accept    = start_i && !start_prev_q && (state_q == S_IDLE);
    assign active    = (state_q == S_SCAN) || (state_q == S_LAUNCH) ||
                       (state_q == S_WAIT) || (state_q == S_NEXT);
    assign last_unit = (idx_q == UNIT_W'(NUM_UNITS - 1));
    assign rise      = unit_end_i[idx_q] && !end_prev_q;

    bist_sched_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (state_q == S_LAUNCH),
        .en_i      (state_q == S_WAIT),
        .expired_o (expired)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mask_d     = mask_q;
        fail_d     = fail_q;
        tmo_d      = tmo_q;
        aborted_d  = aborted_q;
        result_d   = result_q;
        end_prev_d = end_prev_q;

        // Abort leaves the current unit's result bits exactly as they were.
        if (abort_i && active) begin
            state_d   = S_DONE;
            aborted_d = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_d   = S_SCAN;
                        idx_d     = '0;
                        mask_d    = unit_mask_i;
                        fail_d    = '0;
                        tmo_d     = '0;
                        aborted_d = 1'b0;
                        result_d  = 1'b0;
                    end
                end
                S_SCAN: begin
                    if (mask_q[idx_q]) begin
                        state_d = S_LAUNCH;
                    end else if (last_unit) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + UNIT_W'(1);
                    end
                end
                S_LAUNCH: begin
                    state_d    = S_WAIT;
                    end_prev_d = 1'b1;
                end
                S_WAIT: begin
                    end_prev_d = unit_end_i[idx_q];
                    if (rise) begin
                        fail_d[idx_q] = unit_fail_i[idx_q];
                        state_d       = S_NEXT;
                    end else if (expired) begin
                        fail_d[idx_q] = 1'b1;
                        tmo_d[idx_q]  = 1'b1;
                        state_d       = S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (last_unit) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + UNIT_W'(1);
                        state_d = S_SCAN;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            result_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            mask_q       <= '0;
            fail_q       <= '0;
            tmo_q        <= '0;
            aborted_q    <= 1'b0;
            result_q     <= 1'b0;
            end_prev_q   <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            mask_q       <= mask_d;
            fail_q       <= fail_d;
            tmo_q        <= tmo_d;
            aborted_q    <= aborted_d;
            result_q     <= result_d;
            end_prev_q   <= end_prev_d;
            start_prev_q <= start_i;
        end
    end

    always_comb begin
        unit_start_o = '0;
        if (state_q == S_LAUNCH) begin
            unit_start_o[idx_q] = 1'b1;
        end
    end

    // pass is gated by result_q so it reads 0 until a session has actually finished.
    assign cur_unit_o    = idx_q;
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign pass_o        = result_q && (fail_q == '0) && !aborted_q;
    assign aborted_o     = aborted_q;
    assign fail_map_o    = fail_q;
    assign timeout_map_o = tmo_q;

endmodule

// File: tb/tb_bist_scheduler.sv
// tb/tb_bist_scheduler.sv - randomized and directed session checks against a cycle-count reference model
module tb_bist_scheduler;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         sel8 = 1'b0;
    logic [N-1:0] mask = '0;
    logic [N-1:0] uend = '0;
    logic [N-1:0] ufail = '0;
    logic         start_a, start_b;

    logic [N-1:0] us_a, fm_a, tm_a, us_b, fm_b, tm_b;
    logic [1:0]   cu_a, cu_b;
    logic         busy_a, done_a, pass_a, ab_a;
    logic         busy_b, done_b, pass_b, ab_b;

    logic [N-1:0] us, fm, tm;
    logic [1:0]   cu;
    logic         busy, done, pass, ab;

    assign start_a = sel8 ? 1'b0 : start;
    assign start_b = sel8 ? start : 1'b0;
    assign us   = sel8 ? us_b   : us_a;
    assign fm   = sel8 ? fm_b   : fm_a;
    assign tm   = sel8 ? tm_b   : tm_a;
    assign cu   = sel8 ? cu_b   : cu_a;
    assign busy = sel8 ? busy_b : busy_a;
    assign done = sel8 ? done_b : done_a;
    assign pass = sel8 ? pass_b : pass_a;
    assign ab   = sel8 ? ab_b   : ab_a;

    bist_scheduler #(.NUM_UNITS(N), .TIMEOUT(255)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .abort_i(abort),
        .unit_mask_i(mask), .unit_end_i(uend), .unit_fail_i(ufail),
        .unit_start_o(us_a), .cur_unit_o(cu_a), .busy_o(busy_a), .done_o(done_a),
        .pass_o(pass_a), .aborted_o(ab_a), .fail_map_o(fm_a), .timeout_map_o(tm_a)
    );

    bist_scheduler #(.NUM_UNITS(N), .TIMEOUT(8)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .abort_i(abort),
        .unit_mask_i(mask), .unit_end_i(uend), .unit_fail_i(ufail),
        .unit_start_o(us_b), .cur_unit_o(cu_b), .busy_o(busy_b), .done_o(done_b),
        .pass_o(pass_b), .aborted_o(ab_b), .fail_map_o(fm_b), .timeout_map_o(tm_b)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Session stimulus: dly = cycles from pulse to end rise; stale = end held high throughout.
    int           cfg_dly [N];
    logic [N-1:0] cfg_mask, cfg_fail, cfg_stale;

    int           exp_done;
    int           exp_lc [N];
    logic [N-1:0] exp_fm, exp_tm;
    logic         exp_ab;

    // Cycle 1 is the first SCAN. Each skipped unit costs 1 cycle, each run unit 3+k.
    function automatic void model(input int to, input int abort_at);
        int t = 1;
        int k;
        bit timed;
        bit stop = 1'b0;
        exp_fm = '0; exp_tm = '0; exp_ab = 1'b0; exp_done = -1;
        for (int i = 0; i < N; i++) exp_lc[i] = -1;
        for (int i = 0; i < N; i++) begin
            if (stop) continue;
            if (!cfg_mask[i]) begin
                if (abort_at == t) begin
                    exp_done = t + 1; exp_ab = 1'b1; stop = 1'b1;
                end
                t = t + 1;
            end else begin
                timed = cfg_stale[i] || (cfg_dly[i] > to);
                k = timed ? to : cfg_dly[i];
                if (abort_at == 0 || abort_at > t) exp_lc[i] = t + 1;
                if (abort_at != 0 && abort_at >= t && abort_at <= t + 1 + k) begin
                    exp_done = abort_at + 1; exp_ab = 1'b1; stop = 1'b1;
                end else begin
                    exp_fm[i] = timed | cfg_fail[i];
                    exp_tm[i] = timed;
                    t = t + 3 + k;
                end
            end
        end
        if (!stop) exp_done = t;
    endfunction

    task automatic run_session(input string nm, input bit use8, input int abort_at,
                               input bit hold, input int repulse_at, input int rst_at);
        int lc [N];
        int c = 0;
        int done_c = -1;
        int ndone = 0;
        int nbusy = 0;
        int bad = 0;
        logic [N-1:0] fm_d = '0, tm_d = '0;
        logic pass_d = 1'b0, ab_d = 1'b0;
        logic exp_pass;
        model(use8 ? 8 : 255, abort_at);
        exp_pass = (exp_fm == '0) && !exp_ab;
        for (int i = 0; i < N; i++) lc[i] = -1;
        @(negedge clk);
        sel8 = use8; mask = cfg_mask; ufail = cfg_fail; uend = cfg_stale; abort = 1'b0;
        start = 1'b1;
        while (c < 3000) begin
            @(negedge clk);
            c++;
            if (rst_at != 0 && c == rst_at + 1) begin
                n_chk++;
                if ({us, cu, busy, done, pass, ab, fm, tm} !== 18'd0)
                    $display("FAIL %s reset_outputs got %h want 0", nm,
                             {us, cu, busy, done, pass, ab, fm, tm});
                else n_pass++;
                rst = 1'b0; start = 1'b0; uend = '0;
                for (int j = 0; j < 6; j++) begin
                    @(negedge clk);
                    if (us != '0 || busy) bad++;
                end
                n_chk++;
                if (bad !== 0) $display("FAIL %s post_reset_activity got %0d want 0", nm, bad);
                else n_pass++;
                return;
            end
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (done_c < 0) begin
                    done_c = c; fm_d = fm; tm_d = tm; pass_d = pass; ab_d = ab;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (us[i]) begin
                    if (lc[i] >= 0 || us != (4'(1) << i) || cu != 2'(i)) bad++;
                    else lc[i] = c;
                end
            end
            if (done_c >= 0 && c >= done_c + 3) break;
            start = hold || (c == repulse_at);
            abort = (c == abort_at);
            rst   = (rst_at != 0 && c == rst_at);
            for (int i = 0; i < N; i++)
                uend[i] = cfg_stale[i] || (lc[i] >= 0 && c >= lc[i] + cfg_dly[i]);
        end
        start = 1'b0; abort = 1'b0; uend = '0;
        for (int i = 0; i < N; i++) begin
            n_chk++;
            if (lc[i] !== exp_lc[i])
                $display("FAIL %s pulse_cycle[%0d] got %0d want %0d", nm, i, lc[i], exp_lc[i]);
            else n_pass++;
        end
        n_chk++;
        if (bad !== 0) $display("FAIL %s pulse_shape got %0d bad want 0", nm, bad);
        else n_pass++;
        n_chk++;
        if (done_c !== exp_done) $display("FAIL %s done_cycle got %0d want %0d", nm, done_c, exp_done);
        else n_pass++;
        n_chk++;
        if (ndone !== 1) $display("FAIL %s done_pulses got %0d want 1", nm, ndone);
        else n_pass++;
        n_chk++;
        if (nbusy !== exp_done) $display("FAIL %s busy_cycles got %0d want %0d", nm, nbusy, exp_done);
        else n_pass++;
        n_chk++;
        if (fm_d !== exp_fm) $display("FAIL %s fail_map got %b want %b", nm, fm_d, exp_fm);
        else n_pass++;
        n_chk++;
        if (tm_d !== exp_tm) $display("FAIL %s timeout_map got %b want %b", nm, tm_d, exp_tm);
        else n_pass++;
        n_chk++;
        if (ab_d !== exp_ab) $display("FAIL %s aborted got %b want %b", nm, ab_d, exp_ab);
        else n_pass++;
        n_chk++;
        if (pass_d !== exp_pass) $display("FAIL %s pass got %b want %b", nm, pass_d, exp_pass);
        else n_pass++;
        n_chk++;
        if ({pass, fm} !== {exp_pass, exp_fm})
            $display("FAIL %s held_result got %b want %b", nm, {pass, fm}, {exp_pass, exp_fm});
        else n_pass++;
    endtask

    task automatic set_all_dly(input int d);
        for (int i = 0; i < N; i++) cfg_dly[i] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({us_a, cu_a, busy_a, done_a, pass_a, ab_a, fm_a, tm_a} !== 18'd0)
            $display("FAIL reset_a got %h want 0", {us_a, cu_a, busy_a, done_a, pass_a, ab_a, fm_a, tm_a});
        else n_pass++;
        n_chk++;
        if ({us_b, cu_b, busy_b, done_b, pass_b, ab_b, fm_b, tm_b} !== 18'd0)
            $display("FAIL reset_b got %h want 0", {us_b, cu_b, busy_b, done_b, pass_b, ab_b, fm_b, tm_b});
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (pass_a !== 1'b0 || busy_a !== 1'b0)
            $display("FAIL idle_after_reset got pass=%b busy=%b want 0 0", pass_a, busy_a);
        else n_pass++;
    endtask

    task automatic test_empty_mask();
        cfg_mask = 4'b0000; cfg_fail = '0; cfg_stale = '0; set_all_dly(6);
        run_session("empty_mask", 1'b0, 0, 1'b0, 0, 0);
    endtask

    task automatic test_two_units();
        cfg_mask = 4'b0101; cfg_fail = '0; cfg_stale = '0; set_all_dly(6);
        run_session("two_units", 1'b0, 0, 1'b0, 0, 0);
    endtask

    task automatic test_stale_timeout();
        cfg_mask = 4'b0010; cfg_fail = '0; cfg_stale = 4'b0010; set_all_dly(6);
        run_session("stale_timeout", 1'b0, 0, 1'b0, 0, 0);
    endtask

    task automatic test_rise_wins();
        cfg_mask = 4'b0011; cfg_fail = 4'b0001; cfg_stale = '0;
        cfg_dly[0] = 8; cfg_dly[1] = 9; cfg_dly[2] = 2; cfg_dly[3] = 2;
        run_session("rise_wins", 1'b1, 0, 1'b0, 0, 0);
    endtask

    task automatic test_abort();
        cfg_mask = 4'b1111; cfg_fail = 4'b0001; cfg_stale = '0; set_all_dly(10);
        model(255, 0);
        run_session("abort", 1'b0, exp_lc[1] + 3, 1'b0, 2, 0);
    endtask

    task automatic test_random();
        bit use8;
        for (int s = 0; s < 8; s++) begin
            use8 = 1'($urandom_range(0, 1));
            cfg_mask = 4'($urandom);
            cfg_fail = 4'($urandom);
            for (int i = 0; i < N; i++) begin
                cfg_dly[i] = $urandom_range(2, use8 ? 11 : 20);
                cfg_stale[i] = ($urandom_range(0, 7) == 0);
            end
            run_session($sformatf("random%0d", s), use8, 0, 1'($urandom_range(0, 1)), 0, 0);
        end
    endtask

    task automatic test_reset_mid();
        cfg_mask = 4'b1111; cfg_fail = '0; cfg_stale = '0; set_all_dly(30);
        model(255, 0);
        run_session("reset_mid", 1'b0, 0, 1'b0, 0, exp_lc[0] + 5);
        cfg_fail = 4'b1000;
        for (int i = 0; i < N; i++) cfg_dly[i] = $urandom_range(2, 15);
        run_session("after_reset", 1'b0, 0, 1'b0, 0, 0);
    endtask

    task automatic test_back_to_back();
        cfg_mask = 4'b1001; cfg_fail = 4'b0000; cfg_stale = '0; set_all_dly(3);
        run_session("b2b_first", 1'b0, 0, 1'b1, 0, 0);
        cfg_mask = 4'b0110; cfg_fail = 4'b0100; set_all_dly(2);
        run_session("b2b_second", 1'b0, 0, 1'b0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_empty_mask();
        test_two_units();
        test_stale_timeout();
        test_rise_wins();
        test_abort();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
